mdu_iter: RTL and testbench

Iterative multiply/divide unit for the execute stage, placed beside `alu` and fed the same `a`/`b` operands from the register file. It owns the HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. A start/busy/done handshake allows the control unit to stall the single-cycle core until a result is ready. MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/mdu_if.sv | 16 +
 rtl/mdu_iter.sv | 138 +++++++++++++
 tb/tb_mdu_iter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Execute-stage bus between the control unit and the iterative multiply/divide unit.
interface mdu_if #(
    parameter int unsigned M = 32
);
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [2:0]   op;
    logic         start;
    logic         busy;
    logic         done;
    logic [M-1:0] hi;
    logic [M-1:0] lo;

    modport master (output a, b, op, start, input busy, done, hi, lo);
    modport slave  (input a, b, op, start, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes, sign fix-up applied when the result is written.
module mdu_iter #(
    parameter int unsigned M = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);
    localparam int unsigned CW = $clog2(M) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [2*M-1:0] acc_q;
    logic [M-1:0]   opnd_q;
    logic [M-1:0]   a_raw_q;
    logic           is_div_q;
    logic           bzero_q;
    logic           neg_lo_q;
    logic           neg_hi_q;
    logic           busy_q;
    logic           done_q;
    logic [M-1:0]   hi_q;
    logic [M-1:0]   lo_q;

    logic           a_neg_c;
    logic           b_neg_c;
    logic [M-1:0]   mag_a_c;
    logic [M-1:0]   mag_b_c;
    logic [M:0]     mul_sum_c;
    logic [2*M-1:0] mul_next_c;
    logic [M:0]     div_shift_c;
    logic [M:0]     div_diff_c;
    logic [2*M-1:0] div_next_c;
    logic [2*M-1:0] prod_fix_c;
    logic [M-1:0]   quot_fix_c;
    logic [M-1:0]   rem_fix_c;

    // Operand magnitudes at latch time; op[0] marks the signed variants.
    always_comb begin
        a_neg_c = bus.op[0] & bus.a[M-1];
        b_neg_c = bus.op[0] & bus.b[M-1];
        mag_a_c = a_neg_c ? (~bus.a + M'(1)) : bus.a;
        mag_b_c = b_neg_c ? (~bus.b + M'(1)) : bus.b;
    end

    // One iteration step for both algorithms, sharing acc_q as {upper, lower} halves.
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[2*M-1:M]} + (acc_q[0] ? {1'b0, opnd_q} : (M+1)'(0));
        mul_next_c  = {mul_sum_c, acc_q[M-1:1]};
        div_shift_c = acc_q[2*M-1:M-1];
        div_diff_c  = div_shift_c - {1'b0, opnd_q};
        div_next_c  = div_diff_c[M] ? {acc_q[2*M-2:0], 1'b0}
                                    : {div_diff_c[M-1:0], acc_q[M-2:0], 1'b1};
    end

    // Sign fix-up of the finished magnitude result.
    always_comb begin
        prod_fix_c = neg_lo_q ? (~acc_q + (2*M)'(1)) : acc_q;
        quot_fix_c = neg_lo_q ? (~acc_q[M-1:0] + M'(1)) : acc_q[M-1:0];
        rem_fix_c  = neg_hi_q ? (~acc_q[2*M-1:M] + M'(1)) : acc_q[2*M-1:M];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            is_div_q <= 1'b0;
            bzero_q  <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div_q <= bus.op[1];
                                bzero_q  <= (bus.b == '0);
                                a_raw_q  <= bus.a;
                                neg_lo_q <= a_neg_c ^ b_neg_c;
                                neg_hi_q <= a_neg_c;
                                // Multiply shifts the multiplier out of the low half;
                                // divide shifts the dividend out of it.
                                acc_q    <= bus.op[1] ? {M'(0), mag_a_c} : {M'(0), mag_b_c};
                                opnd_q   <= bus.op[1] ? mag_b_c : mag_a_c;
                                cnt_q    <= '0;
                                busy_q   <= 1'b1;
                                state_q  <= RUN;
                            end
                            3'b100:  hi_q <= bus.a;
                            3'b101:  lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc_q <= is_div_q ? div_next_c : mul_next_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(M - 1)) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= prod_fix_c;
                    end else if (bzero_q) begin
                        hi_q <= a_raw_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix_c;
                        lo_q <= quot_fix_c;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: signed/unsigned results, divide corners, handshake, MTHI/MTLO, reset.
module tb_mdu_iter;
    localparam int unsigned M = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   done_seen;
    int   cyc;
    int   d0;

    mdu_if #(.M(M)) bus ();

    mdu_iter #(.M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done) done_seen++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called just after a negedge; presents a one-cycle start.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; counts busy cycles on the way.
    task automatic wait_done(output int busy_cyc);
        bit ok;
        ok = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) busy_cyc++;
        end
        if (!ok) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        done_seen = 0;
        rst_n     = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.op    = 3'b000;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi",   64'(bus.hi),   64'd0);
        check("rst_lo",   64'(bus.lo),   64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b000, 32'hFFFF_FFFF, 32'd2);
        wait_done(cyc);
        check("multu_busy_cycles", 64'(cyc), 64'd33);
        check("multu_hi", 64'(bus.hi), 64'h0000_0001);
        check("multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);
        @(negedge clk);
        check("done_falls", 64'(bus.done), 64'd0);

        issue(3'b001, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc);
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);

        issue(3'b011, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        check("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        issue(3'b011, 32'd100, 32'hFFFF_FFF9);
        wait_done(cyc);
        check("div_negb_lo", 64'(bus.lo), 64'hFFFF_FFF2);
        check("div_negb_hi", 64'(bus.hi), 64'd2);

        issue(3'b010, 32'd7, 32'd0);
        wait_done(cyc);
        check("divz_busy_cycles", 64'(cyc), 64'd33);
        check("divz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        check("divz_hi", 64'(bus.hi), 64'd7);

        issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        check("divovf_lo", 64'(bus.lo), 64'h8000_0000);
        check("divovf_hi", 64'(bus.hi), 64'd0);
        // Start presented while done is high must be taken.
        issue(3'b010, 32'd100, 32'd7);
        @(negedge clk);
        check("b2b_accepted", 64'(bus.busy), 64'd1);
        wait_done(cyc);
        check("b2b_lo", 64'(bus.lo), 64'd14);
        check("b2b_hi", 64'(bus.hi), 64'd2);

        @(negedge clk);
        d0 = done_seen;
        issue(3'b000, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        issue(3'b010, 32'd100, 32'd7);
        bus.a = 32'd55;
        bus.b = 32'd66;
        wait_done(cyc);
        check("ign_hi", 64'(bus.hi), 64'd0);
        check("ign_lo", 64'(bus.lo), 64'd12);
        repeat (3) @(negedge clk);
        check("ign_busy_after", 64'(bus.busy), 64'd0);
        check("ign_done_pulses", 64'(done_seen - d0), 64'd1);

        d0 = done_seen;
        issue(3'b100, 32'h1234_5678, 32'd0);
        check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        check("mthi_lo_kept", 64'(bus.lo), 64'd12);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        issue(3'b101, 32'h0000_CAFE, 32'd0);
        check("mtlo_lo", 64'(bus.lo), 64'h0000_CAFE);
        check("mtlo_hi_kept", 64'(bus.hi), 64'h1234_5678);
        @(negedge clk);
        issue(3'b110, 32'hDEAD_BEEF, 32'd1);
        @(negedge clk);
        check("noop_busy", 64'(bus.busy), 64'd0);
        check("noop_hi", 64'(bus.hi), 64'h1234_5678);
        check("noop_lo", 64'(bus.lo), 64'h0000_CAFE);
        check("mt_no_done", 64'(done_seen - d0), 64'd0);

        issue(3'b001, 32'hFFFF_FFFD, 32'd5);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_hi",   64'(bus.hi),   64'd0);
        check("arst_lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'b000, 32'd6, 32'd7);
        wait_done(cyc);
        check("post_rst_busy_cycles", 64'(cyc), 64'd33);
        check("post_rst_lo", 64'(bus.lo), 64'd42);
        check("post_rst_hi", 64'(bus.hi), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
